// File: rtl/cache_ram_responder_pkg.sv
// Shared types for the cache block-RAM responder: FSM state encodings.
package cache_ram_responder_pkg;

    typedef enum logic [2:0] {
        RAM_STAT_IDLE     = 3'd0,
        RAM_STAT_RD_ISSUE = 3'd1,
        RAM_STAT_RD_DRAIN = 3'd2,
        RAM_STAT_WR       = 3'd3,
        RAM_STAT_RESP     = 3'd4
    } ram_stat_e;

endpackage

// File: rtl/mem_lat_pipe.sv
// Read-return tracker: a LATENCY-deep shift register of {valid, offset};
// the output stage lines up with the word memory's read data.
module mem_lat_pipe #(
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned OFFSET_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [OFFSET_WIDTH-1:0] in_off,
    output logic                    out_vld,
    output logic [OFFSET_WIDTH-1:0] out_off
);

    logic [LATENCY-1:0]                   vld_q;
    logic [LATENCY-1:0][OFFSET_WIDTH-1:0] off_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            off_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            off_q[0] <= in_off;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                off_q[i] <= off_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out_off = off_q[LATENCY-1];

endmodule

// File: rtl/cache_ram_responder.sv
// Serves cache block refills/write-backs as word accesses to a fixed-latency memory.
// Optional: define CACHE_RAM_CRITICAL_WORD_FIRST_EN to start reads at the requested word.
module cache_ram_responder
    import cache_ram_responder_pkg::*;
#(
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH   = 30,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 2,
    localparam int unsigned BLOCK_SIZE  = 1 << OFFSET_WIDTH,
    localparam int unsigned BLOCK_WIDTH = DATA_WIDTH * BLOCK_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ram_en,
    input  logic                   ram_write,
    input  logic [ADDR_WIDTH-1:0]  ram_addr,
    input  logic [BLOCK_WIDTH-1:0] dc_data_wb,
    output logic                   ram_ready,
    output logic [BLOCK_WIDTH-1:0] block_from_ram,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam int unsigned CW     = OFFSET_WIDTH + 1;
    localparam int unsigned BASE_W = ADDR_WIDTH - OFFSET_WIDTH;
`ifdef CACHE_RAM_CRITICAL_WORD_FIRST_EN
    localparam logic CWF_EN = 1'b1;
`else
    localparam logic CWF_EN = 1'b0;
`endif

    ram_stat_e                             state_q, state_d;
    logic [BASE_W-1:0]                     base_q;
    logic [OFFSET_WIDTH-1:0]               start_q;
    logic [CW-1:0]                         seq_cnt_q, recv_cnt_q;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_q, blk_ret;
    logic [OFFSET_WIDTH-1:0]               seq_off, issue_off, ret_off;
    logic                                  ret_vld, last_seq, last_recv;

    assign seq_off   = seq_cnt_q[OFFSET_WIDTH-1:0];
    assign issue_off = start_q + seq_off;
    assign last_seq  = (seq_cnt_q == CW'(BLOCK_SIZE - 1));
    // Final word arrives this cycle: jump straight to RESP so ready lands on N+L+1.
    assign last_recv = ret_vld && (recv_cnt_q == CW'(BLOCK_SIZE - 1));

    mem_lat_pipe #(
        .LATENCY      (MEM_LATENCY),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (state_q == RAM_STAT_RD_ISSUE),
        .in_off  (issue_off),
        .out_vld (ret_vld),
        .out_off (ret_off)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RAM_STAT_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; RESP always returns to IDLE so a held ram_en yields one pulse
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RAM_STAT_IDLE:     if (ram_en) state_d = ram_write ? RAM_STAT_WR : RAM_STAT_RD_ISSUE;
            RAM_STAT_RD_ISSUE: if (last_seq) state_d = RAM_STAT_RD_DRAIN;
            RAM_STAT_RD_DRAIN: if (last_recv) state_d = RAM_STAT_RESP;
            RAM_STAT_WR:       if (last_seq) state_d = RAM_STAT_RESP;
            RAM_STAT_RESP:     state_d = RAM_STAT_IDLE;
            default:           state_d = RAM_STAT_IDLE;
        endcase
    end

    // Backing-memory strobes decoded from state and counters
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == RAM_STAT_RD_ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = {base_q, issue_off};
        end else if (state_q == RAM_STAT_WR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {base_q, seq_off};
            mem_wdata = blk_q[seq_off];
        end
    end

    // Block buffer with the returning word merged in
    always_comb begin
        blk_ret = blk_q;
        if (ret_vld) blk_ret[ret_off] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q         <= '0;
            start_q        <= '0;
            seq_cnt_q      <= '0;
            recv_cnt_q     <= '0;
            blk_q          <= '0;
            block_from_ram <= '0;
            ram_ready      <= 1'b0;
        end else begin
            blk_q     <= blk_ret;
            ram_ready <= (state_d == RAM_STAT_RESP);
            if (ret_vld) recv_cnt_q <= recv_cnt_q + CW'(1);
            unique case (state_q)
                RAM_STAT_IDLE: if (ram_en) begin
                    base_q     <= ram_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
                    start_q    <= (CWF_EN && !ram_write) ? ram_addr[OFFSET_WIDTH-1:0] : '0;
                    seq_cnt_q  <= '0;
                    recv_cnt_q <= '0;
                    if (ram_write) blk_q <= dc_data_wb;
                end
                RAM_STAT_RD_ISSUE, RAM_STAT_WR: seq_cnt_q <= seq_cnt_q + CW'(1);
                RAM_STAT_RD_DRAIN: if (last_recv) block_from_ram <= blk_ret;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ram_responder.sv
// Directed bench for cache_ram_responder with a latency-2 word memory model.
module tb_cache_ram_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         ram_en;
    logic         ram_write;
    logic [29:0]  ram_addr;
    logic [255:0] dc_data_wb;
    logic         ram_ready;
    logic [255:0] block_from_ram;
    logic         mem_en;
    logic         mem_we;
    logic [29:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    cache_ram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_write      (ram_write),
        .ram_addr       (ram_addr),
        .dc_data_wb     (dc_data_wb),
        .ram_ready      (ram_ready),
        .block_from_ram (block_from_ram),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: request captured mid-cycle, data returned two cycles after issue
    logic [31:0] mem [0:255];
    logic        req_v, p0_v, p1_v;
    logic [7:0]  req_a, p0_a, p1_a;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        req_v = 1'b0; p0_v = 1'b0; p1_v = 1'b0;
        req_a = '0;   p0_a = '0;   p1_a = '0;
    end

    always @(negedge clk) begin
        req_v <= mem_en && !mem_we;
        req_a <= mem_addr[7:0];
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    always @(posedge clk) begin
        p0_v <= req_v; p0_a <= req_a;
        p1_v <= p0_v;  p1_a <= p0_a;
    end

    assign mem_rdata = p1_v ? mem[p1_a] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [255:0] ramp(input logic [31:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = b + 32'(i);
        return r;
    endfunction

    // Called at the start of cycle 0; returns at the start of the IDLE cycle after RESP
    task automatic xact(input logic wr, input logic [29:0] addr, input logic [255:0] wb,
                        input logic [255:0] exp_blk, input logic keep_en);
        int          lat;
        logic [2:0]  start;
        logic [2:0]  off;
        lat   = wr ? 9 : 11;
        start = 3'd0;
`ifdef CACHE_RAM_CRITICAL_WORD_FIRST_EN
        if (!wr) start = addr[2:0];
`endif
        ram_en = 1'b1; ram_write = wr; ram_addr = addr; dc_data_wb = wb;
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                ram_write  = ~wr;
                ram_addr   = addr ^ 30'h155;
                dc_data_wb = ~wb;
            end
            if (k == lat && !keep_en) ram_en = 1'b0;
            chk("ready", 256'(ram_ready), 256'(k == lat));
            if (k <= 8) begin
                off = start + 3'(k - 1);
                if (wr) chk("wr_beat", {mem_en, mem_we, mem_addr, mem_wdata},
                            {1'b1, 1'b1, addr[29:3], 3'(k - 1), wb[(k-1)*32 +: 32]});
                else    chk("rd_beat", {mem_en, mem_we, mem_addr},
                            {1'b1, 1'b0, addr[29:3], off});
            end else begin
                chk("mem_idle", 256'(mem_en), 256'(0));
            end
            if (k >= lat) chk("block", block_from_ram, exp_blk);
        end
    endtask

    initial begin
        rst = 1'b0; ram_en = 1'b0; ram_write = 1'b0; ram_addr = '0; dc_data_wb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 256'(ram_ready), 256'(0));
        chk("rst_mem",   {mem_en, mem_we, mem_addr, mem_wdata}, 256'(0));
        chk("rst_block", block_from_ram, 256'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_mem", 256'(mem_en), 256'(0));

        xact(1'b0, 30'h40, '0,          ramp(32'h40), 1'b0);
        xact(1'b1, 30'h80, ramp(32'hA0), ramp(32'h40), 1'b0);
        xact(1'b0, 30'h45, '0,          ramp(32'h40), 1'b0);
        xact(1'b1, 30'h80, ramp(32'hB0), ramp(32'h40), 1'b1);
        xact(1'b0, 30'h80, '0,          ramp(32'hB0), 1'b0);

        // Abort a read with reset in cycle 5, release in cycle 7
        ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h40;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                rst = 1'b0; ram_en = 1'b0;
                #1;
            end
            if (k == 7) rst = 1'b1;
            if (k < 5) chk("pre_rst_beat", {mem_en, mem_addr}, {1'b1, 30'h40 + 30'(k - 1)});
            else begin
                chk("abort_ready", 256'(ram_ready), 256'(0));
                chk("abort_mem",   256'(mem_en), 256'(0));
            end
            if (k == 6) chk("abort_block", block_from_ram, 256'(0));
        end
        xact(1'b0, 30'h88, '0, ramp(32'h88), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
